// File: rtl/tap_streamer.sv
// Circular tap delay line that streams its TAPS newest samples, newest first,
// over a valid/ready handshake each time a new sample is accepted.
module tap_streamer #(
   parameter int N    = 16,
   parameter int TAPS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic [N-1:0]            d,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N-1:0]            out_data,
   output logic [$clog2(TAPS)-1:0] out_idx,
   output logic                    out_last,
   output logic                    busy,
   output logic                    drop
);

   localparam int IW = $clog2(TAPS);
   localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

   if (TAPS < 2 || (TAPS & (TAPS - 1)) != 0) begin : g_bad_taps
      $error("tap_streamer: TAPS must be a power of two and at least 2");
   end

   typedef enum logic {IDLE, STREAM} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   tap_mem [TAPS];
   logic [IW-1:0]  wr_ptr;
   logic [IW-1:0]  rd_ptr;
   logic [IW-1:0]  idx_nxt;
   logic           xfer;
   logic           final_xfer;
   logic           accept;
   logic           drop_nxt;
   logic           last_nxt;

   // A new sample is taken when idle, or on the very edge that retires the
   // last tap, so back-to-back streams run without a bubble.
   always_comb begin
      xfer       = (state == STREAM) && out_ready;
      final_xfer = xfer && (out_idx == LAST_IDX);
      accept     = ena && ((state == IDLE) || final_xfer);
      drop_nxt   = ena && !accept;
      state_nxt  = state;
      idx_nxt    = out_idx;
      if (accept) begin
         state_nxt = STREAM;
         idx_nxt   = '0;
      end else if (final_xfer) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
      end else if (xfer) begin
         idx_nxt   = out_idx + IW'(1);
      end
      last_nxt = (state_nxt == STREAM) && (idx_nxt == LAST_IDX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         out_idx  <= '0;
         out_last <= 1'b0;
         drop     <= 1'b0;
         wr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         out_idx  <= idx_nxt;
         out_last <= last_nxt;
         drop     <= drop_nxt;
         if (accept) begin
            wr_ptr <= wr_ptr + IW'(1);
         end
      end
   end

   // Entries are cleared on reset so taps not yet written read as zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) begin
            tap_mem[i] <= '0;
         end
      end else if (accept) begin
         tap_mem[wr_ptr] <= d;
      end
   end

   // wr_ptr points one past the newest entry; modular wrap is free since TAPS is 2^IW.
   assign rd_ptr    = wr_ptr - IW'(1) - out_idx;
   assign out_data  = tap_mem[rd_ptr];
   assign out_valid = (state == STREAM);
   assign busy      = (state == STREAM);

endmodule
